// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle parametrised ALU with start/busy/done handshake
//
// One operation per start pulse, executed over K clock edges that depend
// on the opcode: bit-serial add/subtract, single-step logic ops,
// one-bit-per-edge shifts/rotate, shift-add unsigned and signed multiply.
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous active-high reset
//   inp_i      start, sampled only in IDLE
//   opcode_i   operation, latched at start
//   a_i, b_i   operands, latched at start (b_i[S-1:0] is the shift distance)
//   y_o        low result / working register
//   y_ext_o    high half of the product, 0 for non-multiply ops
//   ovf_o      carry / borrow / overflow flag, defined per opcode
//   busy_o     high while an operation is running
//   done_o     one-cycle pulse when the result is valid
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inp_i,
    input  logic [3:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o,
    output logic [N-1:0] y_ext_o,
    output logic         ovf_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int S  = $clog2(N);
    // The step counter must reach N+1 (MULS).
    localparam int CW = $clog2(N + 2);
    localparam int W2 = 2 * N;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SHR  = 4'b0111;
    localparam logic [3:0] OP_SAR  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_MULS = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    y_q, y_d;
    logic [N-1:0]    y_ext_q, y_ext_d;
    logic            ovf_q, ovf_d;
    logic            carry_q, carry_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   k_q, k_d;

    // Combinational step helpers
    logic            last;
    logic            bb;
    logic            sum_bit;
    logic            cout;
    logic [N:0]      acc;
    logic [W2-1:0]   prod;
    logic [N-1:0]    src;
    logic [S-1:0]    shamt;

    // Number of RUN steps for an opcode.
    function automatic logic [CW-1:0] k_of(input logic [3:0] op, input logic [S-1:0] sh);
        logic [CW-1:0] k;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: k = CW'(N);
            OP_MULS:                k = CW'(N + 1);
            OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
                if (sh == '0)
                    k = CW'(1);
                else if (int'(sh) > N)
                    k = CW'(N);
                else
                    k = CW'(sh);
            end
            default:                k = CW'(1);
        endcase
        return k;
    endfunction

    assign shamt = b_q[S-1:0];
    assign last  = (cnt_q == k_q - CW'(1));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        y_ext_d = y_ext_q;
        ovf_d   = ovf_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        bb      = 1'b0;
        sum_bit = 1'b0;
        cout    = 1'b0;
        acc     = '0;
        prod    = '0;
        src     = '0;

        case (state_q)
            ST_IDLE: begin
                if (inp_i) begin
                    state_d = ST_RUN;
                    op_d    = opcode_i;
                    // MULS multiplies magnitudes; the sign is applied in the final step.
                    a_d     = (opcode_i == OP_MULS && a_i[N-1]) ? -a_i : a_i;
                    b_d     = (opcode_i == OP_MULS && b_i[N-1]) ? -b_i : b_i;
                    neg_d   = a_i[N-1] ^ b_i[N-1];
                    y_d     = '0;
                    y_ext_d = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    carry_d = (opcode_i == OP_SUB);
                    k_d     = k_of(opcode_i, b_i[S-1:0]);
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (last)
                    state_d = ST_DONE;

                case (op_q)
                    OP_ADD, OP_SUB: begin
                        // Operands shift right; result bits enter y from the top.
                        bb      = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
                        sum_bit = a_q[0] ^ bb ^ carry_q;
                        cout    = (a_q[0] & bb) | (a_q[0] & carry_q) | (bb & carry_q);
                        y_d     = {sum_bit, y_q[N-1:1]};
                        a_d     = a_q >> 1;
                        b_d     = b_q >> 1;
                        carry_d = cout;
                        if (last)
                            ovf_d = (op_q == OP_SUB) ? ~cout : cout;
                    end
                    OP_AND: y_d = a_q & b_q;
                    OP_OR:  y_d = a_q | b_q;
                    OP_NOT: y_d = ~a_q;
                    OP_XOR: y_d = a_q ^ b_q;
                    OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
                        // y is cleared at start, so the first step works from a.
                        src = (cnt_q == '0) ? a_q : y_q;
                        if (shamt == '0) begin
                            y_d = a_q;
                        end else begin
                            case (op_q)
                                OP_SHL: begin
                                    y_d   = {src[N-2:0], 1'b0};
                                    ovf_d = ovf_q | src[N-1];
                                end
                                OP_SHR:  y_d = {1'b0, src[N-1:1]};
                                OP_SAR:  y_d = {src[N-1], src[N-1:1]};
                                default: y_d = {src[N-2:0], src[N-1]};
                            endcase
                        end
                    end
                    OP_MUL, OP_MULS: begin
                        if (cnt_q < CW'(N)) begin
                            // Shift-add: {y_ext, y} accumulates, b supplies multiplier bits.
                            acc     = {1'b0, y_ext_q} + (b_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
                            y_ext_d = acc[N:1];
                            y_d     = {acc[0], y_q[N-1:1]};
                            b_d     = b_q >> 1;
                            if (last)
                                ovf_d = (acc[N:1] != '0);
                        end else begin
                            // Extra MULS step: apply the sign, then check N-bit signed fit.
                            prod    = neg_q ? (~{y_ext_q, y_q} + W2'(1)) : {y_ext_q, y_q};
                            y_ext_d = prod[W2-1:N];
                            y_d     = prod[N-1:0];
                            ovf_d   = (prod[W2-1:N] != {N{prod[N-1]}});
                        end
                    end
                    default: begin
                        y_d     = '0;
                        y_ext_d = '0;
                        ovf_d   = 1'b0;
                    end
                endcase
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            y_ext_q <= '0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            y_ext_q <= y_ext_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    assign y_o     = y_q;
    assign y_ext_o = y_ext_q;
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the bit-serial `alu`. It executes one operation per `inp` start pulse with a controlled per-opcode latency. It adds a synchronous reset, an explicit `busy`/`done` handshake, XOR, variable-distance shifts and rotate, and signed multiply. It sits in the datapath wherever the serial ALU sat, and its results are sampled on `done`.

## Interface
- `N`, default 8: operand width, N >= 2.
- `S`, default `$clog2(N)`: shift-amount width, derived, not overridden.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset. Synchronous and active-high; it acts only on a `clk` rising edge.
- `inp`  in  1: start. Sampled only in IDLE.
- `opcode`  in  4: operation, latched at start.
- `a`  in  N: operand A, latched at start.
- `b`  in  N: operand B, latched at start. Shifts use `b[S-1:0]` as the distance `shamt`.
- `y`  out  N: low result / working register.
- `y_ext`  out  N: high half of the product; 0 for all non-multiply ops.
- `ovf`  out  1: overflow / carry / borrow flag, defined per op.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse, result valid.

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
  - IDLE: when `inp`=1 at an edge, latch `a`, `b`, `opcode`; clear `y`, `y_ext`, `ovf`; set step count = 0; go to RUN.
  - RUN: perform one step per edge. On the K-th step, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE. `inp` is ignored in DONE.
- `inp` in RUN or DONE is ignored; there is no queueing. If `inp` is held high, a new op starts at the first IDLE edge.
- Opcodes and step count K:
  - 0000 ADD: bit-serial, LSB first, with a carry flop. K=N. `ovf` = carry out.
  - 0001 SUB: bit-serial, a + ~b + 1. K=N. `ovf` = borrow, i.e. a < b unsigned.
  - 0010 AND, 0011 OR, 0100 NOT a, 0101 XOR: K=1. `ovf`=0.
  - 0110 SHL: one position per step. `ovf` = OR of all bits shifted out.
  - 0111 SHR: logical shift. `ovf`=0.
  - 1000 SAR: arithmetic shift, sign bit replicated. `ovf`=0.
  - 1001 ROL: rotate left. `ovf`=0.
  - Shift/rotate step count: K = max(min(`shamt`, N), 1). For `shamt`=0, the single step leaves `y`=a.
  - 1010 MUL: unsigned shift-add, K=N. Result is {`y_ext`,`y`} = a*b (2N bits). `ovf` = (`y_ext` != 0).
  - 1011 MULS: signed. Multiply |a| by |b| in N steps, then one step negates the 2N-bit result if the signs differ. K=N+1. `ovf` = 1 when the product does not fit in N-bit signed.
  - 1100–1111: reserved. K=1, with `y`=`y_ext`=0 and `ovf`=0.
- During shifts, `y` shows the intermediate value after each step. For all other ops, `y`/`y_ext` contents during RUN are unspecified.
- `y`, `y_ext` and `ovf` hold their final values from DONE until the next start.
- All arithmetic is modulo 2^N on `y`. Sign interpretation applies only to SUB borrow (unsigned) and MULS.

## Timing
- Reset: at the edge with `rst`=1, set state=IDLE and `y`=`y_ext`=0, `ovf`=`busy`=`done`=0. `rst` overrides `inp`.
- Reset mid-operation: the op is aborted, no `done` is generated, and the latched operands are discarded.
- Let E0 be the edge that samples `inp`=1 in IDLE:
  - `busy`=1 from E0 until E_K.
  - `done`=1 for exactly the cycle between E_K and E_{K+1}; `busy`=0 in that cycle.
  - The earliest next start is E_{K+2}, so back-to-back ops are spaced K+2 edges apart.
- Latency from start to `done` is K cycles: ADD/SUB/MUL N, MULS N+1, logic 1, shifts as defined above.
- Operand inputs may change freely after E0 without affecting the result.

## Test plan
- Reset: assert `rst` with `inp`=1 → all outputs 0 and no `done`. After release, ADD with a=5, b=13 → `done` 8 cycles after start, `y`=18, `ovf`=0. ADD with a=200, b=100 → `y`=44, `ovf`=1.
- SUB with a=5, b=13 → `y`=0xF8, `ovf`=1. Then AND/OR/NOT/XOR with a=0x05, b=0x0D → `y` = 0x05 / 0x0D / 0xFA / 0x08, each with `done` 1 cycle after start.
- Shifts:
  - SHL, a=0x05, b=3 → `y` steps 0x0A, 0x14, 0x28; `done` at step 3; `ovf`=0.
  - SAR, a=0x90, b=2 → 0xC8, 0xE4.
  - ROL, a=0x81, b=1 → 0x03.
  - SHL, b=0 → `y`=0x05 at K=1.
- Multiply:
  - MUL, a=200, b=100 → `y_ext`=0x4E, `y`=0x20, `ovf`=1, latency 8.
  - MULS, a=0xFD (-3), b=0x05 → `y_ext`=0xFF, `y`=0xF1, `ovf`=0, latency 9.
- Handshake: pulse `inp` in mid-RUN and again in DONE → both ignored, exactly one `done`. Hold `inp` high continuously → starts are spaced K+2 edges apart.
- Abort: assert `rst` at step 4 of MUL → outputs 0 and no `done`. A following ADD with a=1, b=1 → `y`=2.
